jtframe_sys6809_ctl: RTL and testbench
======================================

JTFRAME_SYS6809_CTL -- requirements
Module: jtframe_sys6809_ctl

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, setting the internal RAM address width (2^RAM_AW bytes).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cen, input, 1 bit: base clock enable (12 MHz-equivalent).
REQ-005 SHALL have port cpu_cen, output, 1 bit: CPU bus-cycle enable, nominally cen/4.
REQ-006 SHALL have ports E and Q, outputs, 1 bit each: 6809 quadrature clocks for the external core.
REQ-007 SHALL have port bus_busy, input, 1 bit: external bus request; stalls the CPU.
REQ-008 SHALL have ports rom_cs and rom_ok, inputs, 1 bit each: ROM access and ROM data valid.
REQ-009 SHALL have port waitn, output, 1 bit: low while the CPU is stalled.
REQ-010 SHALL have port irq_edge, input, 1 bit: interrupt source; a rising edge requests an IRQ.
REQ-011 SHALL have port nIRQ, output, 1 bit: latched active-low IRQ to the core.
REQ-012 SHALL have ports BS and BA, inputs, 1 bit each: 6809 bus status from the core.
REQ-013 SHALL have port irq_ack, output, 1 bit: one-clk interrupt-acknowledge pulse.
REQ-014 SHALL have port A, input, 16 bits: CPU address bus.
REQ-015 SHALL have port RnW, input, 1 bit: CPU read-not-write.
REQ-016 SHALL have port ram_cs, input, 1 bit: RAM select, decoded externally.
REQ-017 SHALL have port cpu_dout, input, 8 bits: CPU write data.
REQ-018 SHALL have port ram_dout, output, 8 bits: RAM read data.

Function
REQ-019 SHALL keep a 2-bit phase counter ph that increments (wrapping 3->0) on each clk where cen=1 and no stall is active.
REQ-020 SHALL drive E=ph[1] and Q=ph[1]^ph[0], so Q leads E by a quarter cycle.
REQ-021 SHALL pulse cpu_cen for exactly one clk when cen=1, ph=3 and no stall is active; it SHALL be 0 at all other times.
REQ-022 SHALL treat the CPU as stalled while bus_busy=1, or while rom_cs=1 and rom_ok=0.
REQ-023 SHALL, while stalled, freeze ph, suppress cpu_cen and drive waitn=0.
REQ-024 SHALL resume counting on the first cen after the stall clears, with no phase lost.
REQ-025 SHALL register irq_edge every clk and detect a rising edge when the previous sample is 0 and the current sample is 1.
REQ-026 SHALL update the IRQ latch in this priority: irq_ack clears it first, then a detected edge sets it; nIRQ SHALL equal ~latch.
REQ-027 SHALL set the latch when an edge and an irq_ack occur on the same clk, so the new request is not lost.
REQ-028 SHALL drive irq_ack=1 for one clk on cpu_cen when BS=1 and BA=0 (vector fetch).
REQ-029 SHALL write cpu_dout to RAM[A[RAM_AW-1:0]] on clk when cpu_cen=1, ram_cs=1 and RnW=0.
REQ-030 SHALL read RAM synchronously: ram_dout is RAM[A[RAM_AW-1:0]] registered every clk, giving 1-clk latency, well inside one cpu_cen period.
REQ-031 SHALL leave RAM contents unaffected by reset; they are undefined at power-up.

Reset
REQ-032 SHALL, while rstn=0: set ph=0, cpu_cen=0, E=0, Q=0, irq_ack=0, the IRQ latch=0 (nIRQ=1), the irq_edge sample register=0 and ram_dout=0.
REQ-033 SHALL begin counting on the first cen after rstn deasserts; an irq_edge input already high at release SHALL register as one rising edge.

Verification
REQ-034 SHALL pass this scenario: cen every 2 clk, no stall -> cpu_cen once every 8 clk; E,Q sequence over ph 0..3 is 00,01,11,10.
REQ-035 SHALL pass this scenario: rom_cs=1, rom_ok=0 for 20 clk -> waitn=0, no cpu_cen, E/Q frozen; rom_ok=1 -> counting resumes from the frozen ph.
REQ-036 SHALL pass this scenario: irq_edge 0->1 -> nIRQ=0 one clk later; irq_edge held high -> no re-trigger; BS=1, BA=0 on cpu_cen -> irq_ack pulse and nIRQ=1 next clk.
REQ-037 SHALL pass this scenario: irq_edge rising edge on the same clk as irq_ack -> nIRQ remains 0.
REQ-038 SHALL pass this scenario: write 0xA5 at A=0x1234 with RAM_AW=12 and ram_cs=1, then read A=0x0234 -> ram_dout=0xA5; a write with cpu_cen=0 does not change RAM.
REQ-039 SHALL pass this scenario: rstn pulsed low mid-cycle with nIRQ=0 and ph=2 -> nIRQ=1, ph=0, cpu_cen=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/jtframe_sys6809_ctl.sv
// jtframe_sys6809_ctl
// Support logic around an external 6809 core. It provides:
//   - the E/Q quadrature clocks and the CPU bus-cycle enable (cpu_cen),
//     all derived from a 2-bit phase counter advanced by the base enable;
//   - CPU stalling while an external master owns the bus or ROM data is late;
//   - an edge-triggered, latched IRQ with acknowledge on the vector fetch;
//   - a small synchronous RAM with 1-clk read latency.
//
// Stall semantics (the single flow-control rule of this block):
//   The CPU side may only advance when it is not stalled. A stall is raised by
//   bus_busy=1, or by rom_cs=1 while rom_ok=0. While stalled:
//     - waitn is 0;
//     - ph holds its value;
//     - cpu_cen stays 0.
//   When the stall clears, the next cen resumes counting from the held phase,
//   so no quarter-cycle is lost or repeated.
//
// The phase counter is exposed on the ph output so its state can be observed.

module jtframe_sys6809_ctl #(
    parameter int RAM_AW = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cen,
    output logic        cpu_cen,
    output logic        E,
    output logic        Q,
    input  logic        bus_busy,
    input  logic        rom_cs,
    input  logic        rom_ok,
    output logic        waitn,
    input  logic        irq_edge,
    output logic        nIRQ,
    input  logic        BS,
    input  logic        BA,
    output logic        irq_ack,
    input  logic [15:0] A,
    input  logic        RnW,
    input  logic        ram_cs,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  ram_dout,
    output logic [1:0]  ph
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    // ------------------------------------------------------------------
    // Stall detection
    // ------------------------------------------------------------------
    logic stall;
    logic advance;

    assign stall   = bus_busy | (rom_cs & ~rom_ok);
    assign advance = cen & ~stall;
    assign waitn   = ~stall;

    // ------------------------------------------------------------------
    // Phase counter: ph 0..3 maps to (E,Q) = 00, 01, 11, 10
    // ------------------------------------------------------------------
    logic [1:0] ph_q;
    logic [1:0] ph_nx;

    // Phase state register, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_q <= 2'd0;
        end else begin
            ph_q <= ph_nx;
        end
    end

    // Next phase: step on every unstalled base enable, wrap 3 -> 0
    always_comb begin
        ph_nx = ph_q;
        if (advance) begin
            ph_nx = ph_q + 2'd1;
        end
    end

    // Phase decode: quadrature clocks and the bus-cycle enable at ph=3
    always_comb begin
        E       = ph_q[1];
        Q       = ph_q[1] ^ ph_q[0];
        cpu_cen = advance & (ph_q == 2'd3);
    end

    assign ph = ph_q;

    // ------------------------------------------------------------------
    // Interrupt request latch
    // ------------------------------------------------------------------
    logic irq_q;
    logic irq_rise;
    logic irq_latch;

    // A vector fetch is signalled by BS=1, BA=0 on a bus cycle.
    assign irq_ack  = cpu_cen & BS & ~BA;
    assign irq_rise = irq_edge & ~irq_q;
    assign nIRQ     = ~irq_latch;

    // Sample the interrupt source every clk for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_edge;
        end
    end

    // Latch update: a new edge wins over a simultaneous acknowledge so that
    // a request arriving during the vector fetch is not dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_latch <= 1'b0;
        end else if (irq_rise) begin
            irq_latch <= 1'b1;
        end else if (irq_ack) begin
            irq_latch <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Internal RAM
    // ------------------------------------------------------------------
    logic [7:0]        mem [0:RAM_DEPTH-1];
    logic [RAM_AW-1:0] addr;
    logic              ram_we;

    assign addr   = A[RAM_AW-1:0];
    assign ram_we = cpu_cen & ram_cs & ~RnW;

    // Address bits above the RAM window are decoded outside this block.
    generate
        if (RAM_AW < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^A[15:RAM_AW];
        end
    endgenerate

    // RAM write port: contents are never reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr] <= cpu_dout;
        end
    end

    // RAM read port: registered every clk, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_dout <= 8'd0;
        end else begin
            ram_dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_jtframe_sys6809_ctl.sv
// Testbench for jtframe_sys6809_ctl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the block.

module tb_jtframe_sys6809_ctl;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cen = 1'b0;
    logic        bus_busy = 1'b0;
    logic        rom_cs = 1'b0;
    logic        rom_ok = 1'b1;
    logic        irq_edge = 1'b0;
    logic        BS = 1'b0;
    logic        BA = 1'b0;
    logic [15:0] A = 16'd0;
    logic        RnW = 1'b1;
    logic        ram_cs = 1'b0;
    logic [7:0]  cpu_dout = 8'd0;

    logic        cpu_cen, E, Q, waitn, nIRQ, irq_ack;
    logic [7:0]  ram_dout;
    logic [1:0]  ph;

    always #5 clk = ~clk;

    jtframe_sys6809_ctl #(.RAM_AW(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cen      (cen),
        .cpu_cen  (cpu_cen),
        .E        (E),
        .Q        (Q),
        .bus_busy (bus_busy),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .waitn    (waitn),
        .irq_edge (irq_edge),
        .nIRQ     (nIRQ),
        .BS       (BS),
        .BA       (BA),
        .irq_ack  (irq_ack),
        .A        (A),
        .RnW      (RnW),
        .ram_cs   (ram_cs),
        .cpu_dout (cpu_dout),
        .ram_dout (ram_dout),
        .ph       (ph)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Model state always describes the DUT as it will be after the next edge
    // once the negedge update has run; inputs are stable from negedge to posedge.
    int         mph = 0;         // quarter-cycle position 0..3
    bit         mlatch = 1'b0;   // pending interrupt request
    bit         mprev = 1'b0;    // last sampled interrupt input
    logic [7:0] mdout = 8'd0;
    bit         mdout_known = 1'b1;
    logic [7:0] mmem [DEPTH];
    bit         mvalid [DEPTH];

    always @(negedge clk) begin
        bit stalled, exp_cen, exp_ack, rise;
        int a;
        if (!rstn) begin
            mph = 0; mlatch = 1'b0; mprev = 1'b0; mdout = 8'd0; mdout_known = 1'b1;
            chk("rst_cpu_cen", cpu_cen, 0);
            chk("rst_E", E, 0);
            chk("rst_Q", Q, 0);
            chk("rst_irq_ack", irq_ack, 0);
            chk("rst_nIRQ", nIRQ, 1);
            chk("rst_ph", ph, 0);
            chk("rst_ram_dout", ram_dout, 0);
        end else begin
            stalled = bus_busy || (rom_cs && !rom_ok);
            exp_cen = cen && !stalled && (mph == 3);
            exp_ack = exp_cen && BS && !BA;
            chk("cpu_cen", cpu_cen, exp_cen);
            chk("E", E, (mph >= 2));
            chk("Q", Q, (mph == 1 || mph == 2));
            chk("waitn", waitn, !stalled);
            chk("irq_ack", irq_ack, exp_ack);
            chk("nIRQ", nIRQ, !mlatch);
            chk("ph", ph, mph);
            if (mdout_known) chk("ram_dout", ram_dout, mdout);
            // predict the coming edge
            rise = irq_edge && !mprev;
            if (rise) mlatch = 1'b1;
            else if (exp_ack) mlatch = 1'b0;
            mprev = irq_edge;
            a = int'(A) % DEPTH;
            mdout = mmem[a];
            mdout_known = mvalid[a];
            if (exp_cen && ram_cs && !RnW) begin
                mmem[a] = cpu_dout;
                mvalid[a] = 1'b1;
            end
            if (cen && !stalled) mph = (mph + 1) % 4;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cens(input int n);
        for (int i = 0; i < n; i++) begin
            cen = 1'b1;
            step();
        end
        cen = 1'b0;
    endtask

    logic [1:0] eq_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // ---------------- stimulus ----------------
    initial begin
        int cnt_cen, cnt_wait, cnt_eq;

        // reset held across two edges
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_ph", ph, 0);
        chk("init_nIRQ", nIRQ, 1);
        chk("init_cpu_cen", cpu_cen, 0);
        chk("init_ram_dout", ram_dout, 0);
        #1 rstn = 1'b1;
        step();

        // quadrature sequence over one full CPU cycle
        for (int k = 1; k <= 4; k++) begin
            cen = 1'b1;
            step();
            chk("seq_ph", ph, k % 4);
            chk("seq_EQ", {E, Q}, eq_seq[k % 4]);
        end
        cen = 1'b0;

        // cen every 2 clk -> cpu_cen once every 8 clk
        cnt_cen = 0;
        for (int i = 0; i < 64; i++) begin
            cen = (i % 2 == 0);
            #1 if (cpu_cen) cnt_cen++;
            step();
        end
        cen = 1'b0;
        chk("cen_div_count", cnt_cen, 8);
        chk("cen_div_ph", ph, 0);

        // ROM wait for 20 clk frozen at ph=3
        cens(3);
        cen = 1'b1; rom_cs = 1'b1; rom_ok = 1'b0;
        cnt_cen = 0; cnt_wait = 0; cnt_eq = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cpu_cen) cnt_cen++;
            if (!waitn) cnt_wait++;
            if ({E, Q} !== 2'b10) cnt_eq++;
            step();
        end
        chk("stall_cpu_cen", cnt_cen, 0);
        chk("stall_waitn", cnt_wait, 20);
        chk("stall_EQ_frozen", cnt_eq, 0);
        rom_ok = 1'b1;
        #1 chk("resume_cpu_cen", cpu_cen, 1);
        step();
        chk("resume_ph", ph, 0);
        rom_cs = 1'b0; cen = 1'b0;

        // IRQ edge, hold, acknowledge
        irq_edge = 1'b0; step();
        irq_edge = 1'b1;
        #1 chk("irq_before_edge", nIRQ, 1);
        step();
        chk("irq_set", nIRQ, 0);
        repeat (3) step();
        chk("irq_held", nIRQ, 0);
        cens(3);
        cen = 1'b1; BS = 1'b1; BA = 1'b0;
        #1 chk("irq_ack_pulse", irq_ack, 1);
        step();
        chk("irq_cleared", nIRQ, 1);
        cen = 1'b0; BS = 1'b0;
        repeat (4) step();
        chk("irq_no_retrigger", nIRQ, 1);

        // edge coinciding with acknowledge keeps the request
        irq_edge = 1'b0; step();
        irq_edge = 1'b1; step();
        chk("irq_set2", nIRQ, 0);
        irq_edge = 1'b0;
        cens(3);
        cen = 1'b1; BS = 1'b1; BA = 1'b0; irq_edge = 1'b1;
        #1 chk("irq_ack_pulse2", irq_ack, 1);
        step();
        chk("irq_edge_and_ack", nIRQ, 0);
        cen = 1'b0; BS = 1'b0;

        // RAM write through an aliased address, then a write without cpu_cen
        cens(3);
        cen = 1'b1; A = 16'h1234; ram_cs = 1'b1; RnW = 1'b0; cpu_dout = 8'hA5;
        step();
        cen = 1'b0; A = 16'h0234; RnW = 1'b1;
        step();
        chk("ram_alias_read", ram_dout, 8'hA5);
        RnW = 1'b0; cpu_dout = 8'h5A;
        step();
        RnW = 1'b1;
        step();
        chk("ram_no_write", ram_dout, 8'hA5);
        ram_cs = 1'b0;

        // asynchronous reset mid-cycle with a pending IRQ at ph=2
        irq_edge = 1'b0; step();
        irq_edge = 1'b1; step();
        cens(2);
        chk("pre_rst_ph", ph, 2);
        chk("pre_rst_nIRQ", nIRQ, 0);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_nIRQ", nIRQ, 1);
        chk("async_rst_ph", ph, 0);
        chk("async_rst_cpu_cen", cpu_cen, 0);
        chk("async_rst_EQ", {E, Q}, 2'b00);
        @(posedge clk);
        #2 rstn = 1'b1;
        step();
        chk("release_irq_high", nIRQ, 0);
        cen = 1'b1; step();
        chk("release_first_cen", ph, 1);
        cen = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cen      = ($urandom_range(0, 1) == 1);
            bus_busy = ($urandom_range(0, 9) == 0);
            rom_cs   = ($urandom_range(0, 2) == 0);
            rom_ok   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) irq_edge = ~irq_edge;
            BS       = ($urandom_range(0, 1) == 1);
            BA       = ($urandom_range(0, 3) == 0);
            ram_cs   = ($urandom_range(0, 1) == 1);
            RnW      = ($urandom_range(0, 1) == 1);
            cpu_dout = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) A = 16'h0234;
            else A = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                #2 rstn = 1'b0;
                @(posedge clk);
                #3 rstn = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
